// File: rtl/mux4_rr_arbiter_pkg.sv
// ============================================================================
// Module      : mux_arb_pkg
// Description : Shared types and constants for the 4-way round-robin mux
//               arbiter: state encoding, requester index type, defaults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_arb_pkg;

    localparam int NUM_REQ      = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_MAX_HOLD = 8;

    // Encoded requester index (0..NUM_REQ-1)
    typedef logic [1:0] idx_t;

    // Controller states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index to one-hot grant vector
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input idx_t i_idx);
        return 4'b0001 << i_idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// ============================================================================
// Module      : rr_pick4
// Description : Combinational 4-way round-robin picker. Returns the first
//               asserted request scanning from i_ptr upward (mod 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  idx_t               i_ptr,
    output idx_t               o_winner,
    output logic               o_any
);

    idx_t w_idx;

    // Scan from the farthest offset down so the nearest request to i_ptr wins
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = i_ptr + idx_t'(k);
            if (i_req[w_idx]) begin
                o_winner = w_idx;
                o_any    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : Round-robin arbiter sharing one 4:1 data mux between four
//               requesters. Drives one-hot grant and mux select, registers
//               the selected data onto dout with a valid flag.
//               Optional macro MUX_ARB_TIMEOUT_EN: pre-empts a grant once it
//               has lasted MAX_HOLD cycles while still requested.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [DATA_W-1:0]  din0,
    input  logic [DATA_W-1:0]  din1,
    input  logic [DATA_W-1:0]  din2,
    input  logic [DATA_W-1:0]  din3,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         sel,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid,
    output logic               busy
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    // State registers
    arb_state_t          r_state;
    idx_t                r_ptr;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [NUM_REQ-1:0]  r_gnt;
    idx_t                r_sel;
    logic [DATA_W-1:0]   r_dout;
    logic                r_dout_valid;

    // Next-state values
    arb_state_t          w_state_nxt;
    idx_t                w_ptr_nxt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic [NUM_REQ-1:0]  w_gnt_nxt;
    idx_t                w_sel_nxt;
    logic [DATA_W-1:0]   w_dout_nxt;
    logic                w_dout_valid_nxt;

    // Arbitration and datapath helpers
    logic                w_sel_req;
    logic                w_timeout;
    logic                w_end;
    logic [NUM_REQ-1:0]  w_pick_req;
    idx_t                w_pick_ptr;
    idx_t                w_win;
    logic                w_any;
    logic [DATA_W-1:0]   w_din_sel;

    assign w_sel_req = req[r_sel];

`ifdef MUX_ARB_TIMEOUT_EN
    assign w_timeout = (r_state == GRANT) && w_sel_req
                       && (r_hold_cnt == HOLD_W'(MAX_HOLD));
`else
    assign w_timeout = 1'b0;
`endif

    // A grant ends on release, or on a forced timeout
    assign w_end = (r_state == GRANT) && (!w_sel_req || w_timeout);

    // One picker serves both idle arbitration and re-arbitration at release.
    // A pre-empted requester stays eligible; the pointer already makes it last.
    always_comb begin
        w_pick_req = req;
        w_pick_ptr = r_ptr;
        if (r_state == GRANT) begin
            w_pick_ptr = r_sel + idx_t'(1);
            if (!w_timeout) begin
                w_pick_req = req & ~idx_to_onehot(r_sel);
            end
        end
    end

    rr_pick4 u_pick (
        .i_req    (w_pick_req),
        .i_ptr    (w_pick_ptr),
        .o_winner (w_win),
        .o_any    (w_any)
    );

    // Shared 4:1 data mux driven by the current select
    always_comb begin
        w_din_sel = din0;
        case (r_sel)
            2'd0:    w_din_sel = din0;
            2'd1:    w_din_sel = din1;
            2'd2:    w_din_sel = din2;
            default: w_din_sel = din3;
        endcase
    end

    // Next-state and output logic for the IDLE/GRANT controller
    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_hold_nxt       = r_hold_cnt;
        w_gnt_nxt        = r_gnt;
        w_sel_nxt        = r_sel;
        w_dout_nxt       = r_dout;
        w_dout_valid_nxt = r_dout_valid;
        case (r_state)
            IDLE: begin
                w_dout_valid_nxt = 1'b0;
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = idx_to_onehot(w_win);
                    w_sel_nxt   = w_win;
                    w_hold_nxt  = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (w_end) begin
                    w_dout_valid_nxt = 1'b0;
                    w_ptr_nxt        = r_sel + idx_t'(1);
                    if (w_any) begin
                        w_gnt_nxt  = idx_to_onehot(w_win);
                        w_sel_nxt  = w_win;
                        w_hold_nxt = HOLD_W'(1);
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else begin
                    w_dout_nxt       = w_din_sel;
                    w_dout_valid_nxt = 1'b1;
                    if (r_hold_cnt != HOLD_W'(MAX_HOLD)) begin
                        w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_hold_cnt   <= '0;
            r_gnt        <= '0;
            r_sel        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_gnt        <= w_gnt_nxt;
            r_sel        <= w_sel_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
        end
    end

    assign gnt        = r_gnt;
    assign sel        = r_sel;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = (r_state == GRANT);

endmodule

`default_nettype wire
